alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Keeps the single-cycle operation set and adds iterative unsigned divide/remainder, with the multiply made iterative.
- Operands enter through a valid/ready handshake. The result is registered and held until the consumer takes it.
- Sits in the EX stage. The pipeline stalls on in_ready_o low or out_valid_o low.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mc_if.sv | 37 +++
 rtl/alu_iter_unit.sv | 85 ++++++++
 rtl/alu_mc.sv | 131 +++++++++++++
 tb/tb_alu_mc.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode encodings and FSM state type shared by the multi-cycle ALU
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND  = 5'd0;
  localparam logic [OP_W-1:0] OP_OR   = 5'd1;
  localparam logic [OP_W-1:0] OP_LW   = 5'd2;
  localparam logic [OP_W-1:0] OP_SW   = 5'd3;
  localparam logic [OP_W-1:0] OP_ADDU = 5'd4;
  localparam logic [OP_W-1:0] OP_SUBU = 5'd5;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd6;
  localparam logic [OP_W-1:0] OP_BLEZ = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd8;
  localparam logic [OP_W-1:0] OP_SRAV = 5'd9;
  localparam logic [OP_W-1:0] OP_LUI  = 5'd10;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd11;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd12;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd13;
  localparam logic [OP_W-1:0] OP_BGTZ = 5'd14;
  localparam logic [OP_W-1:0] OP_DIVU = 5'd16;
  localparam logic [OP_W-1:0] OP_REMU = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mc_if.sv
// ============================================================================
// alu_mc_if : operand/result handshake bundle between EX stage and alu_mc
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface alu_mc_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int OP_W    = 5
) ();

  logic               in_valid_i;
  logic               in_ready_o;
  logic [OP_W-1:0]    op_i;
  logic [WIDTH-1:0]   src1_i;
  logic [WIDTH-1:0]   src2_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [WIDTH-1:0]   result_o;
  logic               zero_o;
  logic               div_by_zero_o;

  modport slave (
    input  in_valid_i, op_i, src1_i, src2_i, shamt_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, div_by_zero_o
  );

  modport master (
    output in_valid_i, op_i, src1_i, src2_i, shamt_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, div_by_zero_o
  );

endinterface

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// ============================================================================
// alu_iter_unit : shift-add multiplier / restoring divider, one bit per cycle
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk_i,
  input  wire logic             rst_n,
  input  wire logic             start_i,
  input  wire logic             is_div_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      prod_o,
  output logic [WIDTH-1:0]      quot_o,
  output logic [WIDTH-1:0]      rem_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, a_q, b_q;
  logic [WIDTH-1:0] acc_d, a_d, b_d;
  logic [WIDTH:0]   trial;

  // acc holds product / partial remainder, a holds multiplier / dividend->quotient
  always_comb begin
    trial = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_d = trial[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (a_q[0]) acc_d = acc_q + b_q;
      a_d = a_q >> 1;
      b_d = b_q << 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= is_div_i;
      cnt_q  <= CNT_W'(WIDTH - 1);
      acc_q  <= '0;
      a_q    <= a_i;
      b_q    <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Final-step values are exposed combinationally so the caller latches them on done
  assign busy_o = busy_q;
  assign done_o = busy_q & (cnt_q == '0);
  assign prod_o = acc_d;
  assign quot_o = a_d;
  assign rem_o  = acc_d;

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// alu_mc   : multi-cycle EX-stage ALU with valid/ready operand and result ports
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int OP_W    = 5
) (
  input  wire logic clk_i,
  input  wire logic rst_n,
  alu_mc_if.slave   bus
);

  import alu_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, single_res, src1_q;
  logic [OP_W-1:0]  op_q;
  logic             zero_q, dbz_q;
  logic             in_ready, accept, is_mul, is_div, div0;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] prod, quot, rem;

  assign in_ready = (state_q == S_IDLE) & ~iter_busy;
  assign accept   = bus.in_valid_i & in_ready;
  assign is_mul   = (bus.op_i == OP_MUL);
  assign is_div   = (bus.op_i == OP_DIVU) | (bus.op_i == OP_REMU);
  assign div0     = is_div & (bus.src2_i == '0);

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .start_i  (accept & (is_mul | (is_div & ~div0))),
    .is_div_i (is_div),
    .a_i      (bus.src1_i),
    .b_i      (bus.src2_i),
    .busy_o   (iter_busy),
    .done_o   (iter_done),
    .prod_o   (prod),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  always_comb begin
    single_res = '0;
    case (bus.op_i)
      OP_AND:                  single_res = bus.src1_i & bus.src2_i;
      OP_OR:                   single_res = bus.src1_i | bus.src2_i;
      OP_LW, OP_SW, OP_ADDU:   single_res = bus.src1_i + bus.src2_i;
      OP_SUBU:                 single_res = bus.src1_i - bus.src2_i;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(bus.src1_i) < $signed(bus.src2_i)};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, bus.src1_i < bus.src2_i};
      OP_BLEZ: single_res = {{(WIDTH-1){1'b0}}, bus.src1_i[WIDTH-1] | ~|bus.src1_i};
      OP_BGTZ: single_res = {{(WIDTH-1){1'b0}}, ~bus.src1_i[WIDTH-1] & |bus.src1_i};
      OP_SRA:  single_res = $signed(bus.src2_i) >>> bus.shamt_i;
      OP_SRAV: single_res = $signed(bus.src2_i) >>> bus.src1_i[SHAMT_W-1:0];
      OP_SLL:  single_res = bus.src2_i << bus.shamt_i;
      OP_LUI:  single_res = {bus.src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: single_res = '0;
    endcase
  end

  // A zero divisor still passes through DIV for one cycle, giving a 2-cycle latency
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul)      state_d = S_MUL;
          else if (is_div) state_d = S_DIV;
          else begin
            state_d  = S_DONE;
            result_d = single_res;
          end
        end
      end
      S_MUL: begin
        if (iter_done) begin
          state_d  = S_DONE;
          result_d = prod;
        end
      end
      S_DIV: begin
        if (dbz_q) begin
          state_d  = S_DONE;
          result_d = (op_q == OP_REMU) ? src1_q : '1;
        end else if (iter_done) begin
          state_d  = S_DONE;
          result_d = (op_q == OP_REMU) ? rem : quot;
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      op_q     <= '0;
      src1_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= ~|result_d;
      if (accept) begin
        op_q   <= bus.op_i;
        src1_q <= bus.src1_i;
        dbz_q  <= div0;
      end
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = (state_q == S_DONE);
  assign bus.result_o      = result_q;
  assign bus.zero_o        = zero_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// tb_alu_mc : directed vector bench for alu_mc at WIDTH=32 and WIDTH=16
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;

  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32), .SHAMT_W(5), .OP_W(5)) if32 ();
  alu_mc_if #(.WIDTH(16), .SHAMT_W(4), .OP_W(5)) if16 ();

  alu_mc #(.WIDTH(32), .SHAMT_W(5), .OP_W(5)) u32 (
    .clk_i (clk), .rst_n (rst_n), .bus (if32.slave));
  alu_mc #(.WIDTH(16), .SHAMT_W(4), .OP_W(5)) u16 (
    .clk_i (clk), .rst_n (rst_n), .bus (if16.slave));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  sh;
    logic [31:0] res;
    int          lat;
    logic        dbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives one request, waits for out_valid (bounded), leaves the result held.
  task automatic run32(input vec_t v, output int lat, output logic busy_ok);
    if32.op_i = v.op; if32.src1_i = v.s1; if32.src2_i = v.s2; if32.shamt_i = v.sh;
    if32.in_valid_i = 1'b1;
    @(posedge clk); #1;
    if32.in_valid_i = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!if32.out_valid_o && lat < 100) begin
      if (if32.in_ready_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release32(input string name);
    if32.out_ready_i = 1'b1;
    @(posedge clk); #1;
    if32.out_ready_i = 1'b0;
    chk({name, "_rel_vld"}, {31'd0, if32.out_valid_o}, 32'd0);
    chk({name, "_rel_rdy"}, {31'd0, if32.in_ready_o}, 32'd1);
  endtask

  task automatic run16(input vec_t v, output int lat);
    if16.op_i = v.op; if16.src1_i = v.s1[15:0]; if16.src2_i = v.s2[15:0];
    if16.shamt_i = v.sh[3:0];
    if16.in_valid_i = 1'b1;
    @(posedge clk); #1;
    if16.in_valid_i = 1'b0;
    lat = 1;
    while (!if16.out_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t tv[20];
  vec_t tv16[3];

  initial begin
    int   lat;
    logic bok;
    logic seen;
    vec_t v;

    tv[0]  = '{OP_ADDU, 32'hFFFF_FFFF, 32'h1,          5'd0, 32'h0,          1,  1'b0};
    tv[1]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,          5'd0, 32'h1,          1,  1'b0};
    tv[2]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,          5'd0, 32'h0,          1,  1'b0};
    tv[3]  = '{OP_SRA,  32'h0,         32'h8000_0000,  5'd4, 32'hF800_0000,  1,  1'b0};
    tv[4]  = '{OP_LUI,  32'h0,         32'h0000_1234,  5'd0, 32'h1234_0000,  1,  1'b0};
    tv[5]  = '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00,  5'd0, 32'h0000_F000,  1,  1'b0};
    tv[6]  = '{OP_OR,   32'h0000_F0F0, 32'h0000_0F0F,  5'd0, 32'h0000_FFFF,  1,  1'b0};
    tv[7]  = '{OP_SUBU, 32'd5,         32'd7,          5'd0, 32'hFFFF_FFFE,  1,  1'b0};
    tv[8]  = '{OP_SRAV, 32'd8,         32'h8000_0000,  5'd0, 32'hFF80_0000,  1,  1'b0};
    tv[9]  = '{OP_BLEZ, 32'd0,         32'd0,          5'd0, 32'h1,          1,  1'b0};
    tv[10] = '{OP_BGTZ, 32'd0,         32'd0,          5'd0, 32'h0,          1,  1'b0};
    tv[11] = '{OP_BGTZ, 32'd5,         32'd0,          5'd0, 32'h1,          1,  1'b0};
    tv[12] = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd0, 32'h1,          33, 1'b0};
    tv[13] = '{OP_MUL,  32'd12345,     32'd678,        5'd0, 32'd8369910,    33, 1'b0};
    tv[14] = '{OP_DIVU, 32'd100,       32'd7,          5'd0, 32'd14,         33, 1'b0};
    tv[15] = '{OP_REMU, 32'd100,       32'd7,          5'd0, 32'd2,          33, 1'b0};
    tv[16] = '{OP_DIVU, 32'd5,         32'd0,          5'd0, 32'hFFFF_FFFF,  2,  1'b1};
    tv[17] = '{OP_ADDU, 32'd3,         32'd4,          5'd0, 32'd7,          1,  1'b0};
    tv[18] = '{OP_REMU, 32'd9,         32'd0,          5'd0, 32'd9,          2,  1'b1};
    tv[19] = '{5'd31,   32'hDEAD_BEEF, 32'h1234_5678,  5'd3, 32'h0,          1,  1'b0};

    tv16[0] = '{OP_MUL, 32'hFFFF, 32'd2,     5'd0,  32'hFFFE, 17, 1'b0};
    tv16[1] = '{OP_LUI, 32'h0,    32'h00AB,  5'd0,  32'hAB00, 1,  1'b0};
    tv16[2] = '{OP_SLL, 32'h0,    32'h0001,  5'd15, 32'h8000, 1,  1'b0};

    if32.in_valid_i = 1'b0; if32.out_ready_i = 1'b0;
    if32.op_i = '0; if32.src1_i = '0; if32.src2_i = '0; if32.shamt_i = '0;
    if16.in_valid_i = 1'b0; if16.out_ready_i = 1'b0;
    if16.op_i = '0; if16.src1_i = '0; if16.src2_i = '0; if16.shamt_i = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  {31'd0, if32.out_valid_o}, 32'd0);
    chk("rst_res",  if32.result_o, 32'd0);
    chk("rst_zero", {31'd0, if32.zero_o}, 32'd1);
    chk("rst_dbz",  {31'd0, if32.div_by_zero_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy",  {31'd0, if32.in_ready_o}, 32'd1);

    for (int i = 0; i < $size(tv); i++) begin
      v = tv[i];
      run32(v, lat, bok);
      chk($sformatf("v%0d_res", i),  if32.result_o, v.res);
      chk($sformatf("v%0d_zero", i), {31'd0, if32.zero_o}, {31'd0, v.res == 32'd0});
      chk($sformatf("v%0d_dbz", i),  {31'd0, if32.div_by_zero_o}, {31'd0, v.dbz});
      chk($sformatf("v%0d_lat", i),  lat, v.lat);
      if (v.lat > 2) chk($sformatf("v%0d_busy_rdy", i), {31'd0, bok}, 32'd1);
      release32($sformatf("v%0d", i));
    end

    // Backpressure: result held and new requests ignored while out_ready is low
    v = '{OP_DIVU, 32'd1000, 32'd10, 5'd0, 32'd100, 33, 1'b0};
    run32(v, lat, bok);
    chk("bp_res", if32.result_o, 32'd100);
    if32.op_i = OP_ADDU; if32.src1_i = 32'd1; if32.src2_i = 32'd1; if32.in_valid_i = 1'b1;
    seen = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (if32.result_o !== 32'd100 || if32.out_valid_o !== 1'b1 || if32.in_ready_o !== 1'b0)
        seen = 1'b0;
    end
    chk("bp_hold", {31'd0, seen}, 32'd1);
    if32.out_ready_i = 1'b1;
    @(posedge clk); #1;
    if32.out_ready_i = 1'b0;
    chk("bp_idle_vld", {31'd0, if32.out_valid_o}, 32'd0);
    chk("bp_idle_rdy", {31'd0, if32.in_ready_o}, 32'd1);
    @(posedge clk); #1;
    if32.in_valid_i = 1'b0;
    chk("bp_new_vld", {31'd0, if32.out_valid_o}, 32'd1);
    chk("bp_new_res", if32.result_o, 32'd2);
    release32("bp");

    // Reset in the middle of a multiply must abort it with no output
    if32.op_i = OP_MUL; if32.src1_i = 32'd7; if32.src2_i = 32'd9; if32.in_valid_i = 1'b1;
    @(posedge clk); #1;
    if32.in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mrst_vld",  {31'd0, if32.out_valid_o}, 32'd0);
    chk("mrst_res",  if32.result_o, 32'd0);
    chk("mrst_zero", {31'd0, if32.zero_o}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_rdy", {31'd0, if32.in_ready_o}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if32.out_valid_o) seen = 1'b1;
    end
    chk("mrst_stale", {31'd0, seen}, 32'd0);
    chk("mrst_res2", if32.result_o, 32'd0);

    for (int i = 0; i < $size(tv16); i++) begin
      v = tv16[i];
      run16(v, lat);
      chk($sformatf("w16_%0d_res", i), {16'd0, if16.result_o}, v.res);
      chk($sformatf("w16_%0d_lat", i), lat, v.lat);
      if16.out_ready_i = 1'b1;
      @(posedge clk); #1;
      if16.out_ready_i = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
